// File: rtl/hex_display_pkg.sv
// Shared constants and the 7-segment decode for the HEX display peripheral.
package hex_display_pkg;

  localparam logic [2:0] ADDR_DIGIT5 = 3'd5;
  localparam logic [2:0] ADDR_CTRL   = 3'd6;
  localparam logic [2:0] ADDR_STATUS = 3'd7;

  localparam int CTRL_EN_LSB     = 0;
  localparam int CTRL_EN_W       = 6;
  localparam int CTRL_BLINK_LSB  = 6;
  localparam int CTRL_BLINK_W    = 6;
  localparam int CTRL_BRIGHT_LSB = 12;
  localparam int CTRL_BRIGHT_W   = 4;

  localparam logic [7:0] VERSION   = 8'h01;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment order g..a, active-low.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_display_timebase.sv
// Free-running PWM step counter and blink phase generator.
module hex_display_timebase #(
  parameter int PWM_DIV    = 64,
  parameter int BLINK_HALF = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] pwm_cnt,
  output logic       blink_phase
);

  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PWM_DIV - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_HALF - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    pwm_q, pwm_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          phase_q, phase_d;

  always_comb begin
    pre_d   = pre_q + PW'(1);
    pwm_d   = pwm_q;
    blk_d   = blk_q + BW'(1);
    phase_d = phase_q;
    if (pre_q == PRE_MAX) begin
      pre_d = '0;
      pwm_d = pwm_q + 4'd1;
    end
    if (blk_q == BLK_MAX) begin
      blk_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= '0;
      pwm_q   <= '0;
      blk_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      pwm_q   <= pwm_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
    end
  end

  assign pwm_cnt     = pwm_q;
  assign blink_phase = phase_q;

endmodule

// File: rtl/hex_display_ctrl.sv
// Avalon-MM slave driving six HEX displays: register file, read mux and
// registered segment/enable outputs with blink and PWM brightness.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int PWM_DIV    = 64,
  parameter int BLINK_HALF = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic [41:0] hex_seg,
  output logic [5:0]  display_en
);

  logic [3:0]  digit_q [6];
  logic [3:0]  digit_d [6];
  logic [5:0]  en_q, en_d;
  logic [5:0]  blink_q, blink_d;
  logic [3:0]  bright_q, bright_d;
  logic [31:0] rdata_q, rdata_d;
  logic [41:0] seg_q, seg_d;
  logic [5:0]  den_q, den_d;

  logic [3:0]  pwm_cnt;
  logic        blink_phase;
  logic        pwm_on;
  logic        unused_wdata;

  assign unused_wdata = ^avs_writedata[31:16];

  hex_display_timebase #(
    .PWM_DIV    (PWM_DIV),
    .BLINK_HALF (BLINK_HALF)
  ) u_timebase (
    .clk         (clk),
    .reset       (reset),
    .pwm_cnt     (pwm_cnt),
    .blink_phase (blink_phase)
  );

  // Register writes; STATUS is read-only so address 7 is ignored.
  always_comb begin
    digit_d  = digit_q;
    en_d     = en_q;
    blink_d  = blink_q;
    bright_d = bright_q;
    if (avs_write) begin
      for (int n = 0; n < 6; n++) begin
        if (avs_address == 3'(n)) digit_d[n] = avs_writedata[3:0];
      end
      if (avs_address == ADDR_CTRL) begin
        en_d     = avs_writedata[CTRL_EN_LSB +: CTRL_EN_W];
        blink_d  = avs_writedata[CTRL_BLINK_LSB +: CTRL_BLINK_W];
        bright_d = avs_writedata[CTRL_BRIGHT_LSB +: CTRL_BRIGHT_W];
      end
    end
  end

  // Read mux samples pre-write state, so a same-cycle read sees the old value.
  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      rdata_d = '0;
      for (int n = 0; n < 6; n++) begin
        if (avs_address == 3'(n)) rdata_d[3:0] = digit_q[n];
      end
      if (avs_address == ADDR_CTRL)
        rdata_d[15:0] = {bright_q, blink_q, en_q};
      if (avs_address == ADDR_STATUS)
        rdata_d[8:0] = {blink_phase, VERSION};
    end
  end

  always_comb begin
    pwm_on = (bright_q == 4'hF) || (pwm_cnt < bright_q);
    seg_d  = '1;
    den_d  = '0;
    for (int n = 0; n < 6; n++) begin
      den_d[n] = en_q[n] & ~(blink_q[n] & blink_phase);
      seg_d[7*n +: 7] = (den_d[n] && pwm_on) ? seg7(digit_q[n]) : SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 6; n++) digit_q[n] <= 4'h0;
      en_q     <= 6'h3F;
      blink_q  <= 6'h00;
      bright_q <= 4'hF;
      rdata_q  <= '0;
      seg_q    <= '1;
      den_q    <= '0;
    end else begin
      digit_q  <= digit_d;
      en_q     <= en_d;
      blink_q  <= blink_d;
      bright_q <= bright_d;
      rdata_q  <= rdata_d;
      seg_q    <= seg_d;
      den_q    <= den_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign hex_seg      = seg_q;
  assign display_en   = den_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: vector table plus blink/PWM/reset sequences.
module tb_hex_display_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [41:0] hex_seg;
  logic [5:0]  display_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hex_display_ctrl #(.PWM_DIV(1), .BLINK_HALF(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .hex_seg       (hex_seg),
    .display_en    (display_en)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] rmask;
    logic [31:0] rexp;
    logic [41:0] seg;
    logic [5:0]  en;
  } vec_t;

  vec_t vecs [12];

  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [41:0] mk(input logic [6:0] h5, h4, h3, h2, h1, h0);
    return {h5, h4, h3, h2, h1, h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    avs_address = a; avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
  endtask

  task automatic pwm_run(input logic [3:0] b, input int exp_lit);
    int  lit;
    logic en_ok;
    wr(3'd6, {16'h0, b, 12'h03F});
    tick();
    lit = 0;
    en_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (hex_seg[41:35] != 7'h7F) lit++;
      if (display_en != 6'h3F) en_ok = 1'b0;
      tick();
    end
    chk($sformatf("pwm_lit_b%0d", b), 64'(lit), 64'(exp_lit));
    chk($sformatf("pwm_en_b%0d", b), 64'(en_ok), 64'd1);
  endtask

  initial begin
    logic [41:0] base;
    logic [6:0]  prev;
    logic        found, blank0, exp_blank;

    reset = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;

    vecs[0]  = '{1'b1, 3'd3, 32'h0000000B, 32'h0, 32'h0, mk(7'h40,7'h40,7'h03,7'h40,7'h40,7'h40), 6'h3F};
    vecs[1]  = '{1'b0, 3'd3, 32'h0, 32'hFFFFFFFF, 32'h0000000B, mk(7'h40,7'h40,7'h03,7'h40,7'h40,7'h40), 6'h3F};
    vecs[2]  = '{1'b1, 3'd0, 32'h12345677, 32'h0, 32'h0, mk(7'h40,7'h40,7'h03,7'h40,7'h40,7'h78), 6'h3F};
    vecs[3]  = '{1'b0, 3'd0, 32'h0, 32'hFFFFFFFF, 32'h00000007, mk(7'h40,7'h40,7'h03,7'h40,7'h40,7'h78), 6'h3F};
    vecs[4]  = '{1'b1, 3'd6, 32'h0000F015, 32'h0, 32'h0, mk(7'h7F,7'h40,7'h7F,7'h40,7'h7F,7'h78), 6'h15};
    vecs[5]  = '{1'b0, 3'd6, 32'h0, 32'hFFFFFFFF, 32'h0000F015, mk(7'h7F,7'h40,7'h7F,7'h40,7'h7F,7'h78), 6'h15};
    vecs[6]  = '{1'b1, 3'd7, 32'hFFFFFFFF, 32'h0, 32'h0, mk(7'h7F,7'h40,7'h7F,7'h40,7'h7F,7'h78), 6'h15};
    vecs[7]  = '{1'b0, 3'd7, 32'h0, 32'hFFFFFEFF, 32'h00000001, mk(7'h7F,7'h40,7'h7F,7'h40,7'h7F,7'h78), 6'h15};
    vecs[8]  = '{1'b1, 3'd6, 32'hFFFFF03F, 32'h0, 32'h0, mk(7'h40,7'h40,7'h03,7'h40,7'h40,7'h78), 6'h3F};
    vecs[9]  = '{1'b0, 3'd6, 32'h0, 32'hFFFFFFFF, 32'h0000F03F, mk(7'h40,7'h40,7'h03,7'h40,7'h40,7'h78), 6'h3F};
    vecs[10] = '{1'b1, 3'd1, 32'hFFFFFFFA, 32'h0, 32'h0, mk(7'h40,7'h40,7'h03,7'h40,7'h08,7'h78), 6'h3F};
    vecs[11] = '{1'b0, 3'd1, 32'h0, 32'hFFFFFFFF, 32'h0000000A, mk(7'h40,7'h40,7'h03,7'h40,7'h08,7'h78), 6'h3F};

    // Power-on reset held for three cycles.
    repeat (3) tick();
    chk("rst_seg", hex_seg, 64'h3FFFFFFFFFF);
    chk("rst_en", display_en, 64'h0);
    chk("rst_rdata", avs_readdata, 64'h0);
    reset = 1'b0;
    tick();
    chk("post_rst_seg", hex_seg, mk(7'h40,7'h40,7'h40,7'h40,7'h40,7'h40));
    chk("post_rst_en", display_en, 64'h3F);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
      else            rd(vecs[i].addr);
      tick();
      chk($sformatf("vec%0d_seg", i), hex_seg, vecs[i].seg);
      chk($sformatf("vec%0d_en", i), display_en, vecs[i].en);
      if (vecs[i].rmask != 32'h0)
        chk($sformatf("vec%0d_rdata", i), avs_readdata & vecs[i].rmask, vecs[i].rexp);
    end

    for (int v = 0; v < 16; v++) begin
      wr(3'd5, 32'(v));
      tick();
      chk($sformatf("seg7_%0h", v), hex_seg[41:35], seg_ref[v]);
    end
    wr(3'd5, 32'h0);
    base = mk(7'h40,7'h40,7'h03,7'h40,7'h08,7'h78);

    // Blink on digit 0 with a 4-cycle half period; STATUS read held open.
    wr(3'd6, 32'h0000F07F);
    avs_address = 3'd7; avs_read = 1'b1;
    tick();
    prev = hex_seg[6:0];
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (hex_seg[6:0] !== prev) found = 1'b1;
      prev = hex_seg[6:0];
    end
    chk("blink_edge_seen", 64'(found), 64'd1);
    blank0 = (prev == 7'h7F);
    for (int k = 0; k < 16; k++) begin
      exp_blank = blank0 ^ ((k / 4) % 2 == 1);
      chk($sformatf("blink_hex0_%0d", k), hex_seg[6:0], exp_blank ? 7'h7F : 7'h78);
      chk($sformatf("blink_en_%0d", k), display_en, exp_blank ? 6'h3E : 6'h3F);
      chk($sformatf("blink_status_%0d", k), avs_readdata[8], exp_blank);
      chk($sformatf("blink_others_%0d", k), hex_seg[41:7], base[41:7]);
      tick();
    end
    avs_read = 1'b0;

    pwm_run(4'd4, 4);
    pwm_run(4'd0, 0);
    pwm_run(4'd15, 16);

    // Same-cycle read and write of CTRL.
    avs_address = 3'd6; avs_writedata = 32'h00001001; avs_read = 1'b1; avs_write = 1'b1;
    tick();
    avs_read = 1'b0; avs_write = 1'b0;
    chk("rw_same_old", avs_readdata, 64'h0000F03F);
    rd(3'd6);
    chk("rw_same_new", avs_readdata, 64'h00001001);

    // Reset in mid-operation.
    reset = 1'b1;
    tick();
    chk("mid_rst_seg", hex_seg, 64'h3FFFFFFFFFF);
    chk("mid_rst_en", display_en, 64'h0);
    chk("mid_rst_rdata", avs_readdata, 64'h0);
    reset = 1'b0;
    tick();
    chk("mid_post_seg", hex_seg, mk(7'h40,7'h40,7'h40,7'h40,7'h40,7'h40));
    chk("mid_post_en", display_en, 64'h3F);
    rd(3'd6);
    chk("mid_post_ctrl", avs_readdata, 64'h0000F03F);
    rd(3'd3);
    chk("mid_post_digit3", avs_readdata, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
